// File: rtl/adder_measure_ctrl.sv
// Wishbone-slave sequencer for the instrumented ripple adder: holds operands, times the ring
// oscillator, captures count and sum. Define MEASURE_CTRL_IRQ_EN for the completion interrupt.
module adder_measure_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int          ADDER_W       = 32,
  parameter int          COUNT_W       = 32,
  parameter int          SETTLE_CYCLES = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [ADDER_W-1:0] adder_a,
  output logic [ADDER_W-1:0] adder_b,
  input  logic [ADDER_W-1:0] adder_sum,
  output logic               ring_en,
  output logic               cnt_clear,
  input  logic [COUNT_W-1:0] ring_count,
  output logic               busy,
  output logic               irq
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE} state_t;

  state_t             state_q;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [31:0]        a_q, a_d, b_q, b_d, run_q, run_d;
  logic               start_req_q, start_req_d, abort_req_q, abort_req_d;
  logic               busy_q, done_q, ring_en_q, cnt_clear_q;
  logic [31:0]        run_cnt_q;
  logic [SET_W-1:0]   settle_cnt_q;
  logic [COUNT_W-1:0] ring_count_q;
  logic [ADDER_W-1:0] sum_q;
  logic               irq_bit;
  logic               access, lock;

`ifdef MEASURE_CTRL_IRQ_EN
  logic irq_pend_q, clr_req_q, clr_req_d;
  assign irq_bit = irq_pend_q;
`else
  assign irq_bit = 1'b0;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  // ack_q gates re-entry so every access gets exactly one single-cycle ack
  assign access = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign lock   = busy_q | start_req_q;

  always_comb begin
    ack_d       = access;
    dat_d       = 32'h0;
    a_d         = a_q;
    b_d         = b_q;
    run_d       = run_q;
    start_req_d = 1'b0;
    abort_req_d = 1'b0;
`ifdef MEASURE_CTRL_IRQ_EN
    clr_req_d   = 1'b0;
`endif
    if (access && wbs_we_i) begin
      case (wbs_adr_i[7:0])
        8'h00: if (wbs_sel_i[0]) begin
          start_req_d = wbs_dat_i[0];
          abort_req_d = wbs_dat_i[1];
`ifdef MEASURE_CTRL_IRQ_EN
          clr_req_d   = wbs_dat_i[2];
`endif
        end
        8'h04: if (!lock) a_d = merge_bytes(a_q, wbs_dat_i, wbs_sel_i);
        8'h08: if (!lock) b_d = merge_bytes(b_q, wbs_dat_i, wbs_sel_i);
        8'h0C: if (!lock) run_d = merge_bytes(run_q, wbs_dat_i, wbs_sel_i);
        default: ;
      endcase
    end else if (access) begin
      case (wbs_adr_i[7:0])
        8'h00:   dat_d = {29'h0, irq_bit, done_q, busy_q};
        8'h04:   dat_d = a_q;
        8'h08:   dat_d = b_q;
        8'h0C:   dat_d = run_q;
        8'h10:   dat_d = 32'(ring_count_q);
        8'h14:   dat_d = 32'(sum_q);
        default: dat_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      run_q       <= 32'h0;
      start_req_q <= 1'b0;
      abort_req_q <= 1'b0;
`ifdef MEASURE_CTRL_IRQ_EN
      clr_req_q   <= 1'b0;
`endif
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      a_q         <= a_d;
      b_q         <= b_d;
      run_q       <= run_d;
      start_req_q <= start_req_d;
      abort_req_q <= abort_req_d;
`ifdef MEASURE_CTRL_IRQ_EN
      clr_req_q   <= clr_req_d;
`endif
    end
  end

  // Control requests arrive one cycle after the ack, so cnt_clear trails the START ack by one cycle
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ring_en_q    <= 1'b0;
      cnt_clear_q  <= 1'b0;
      run_cnt_q    <= 32'h0;
      settle_cnt_q <= '0;
      ring_count_q <= '0;
      sum_q        <= '0;
`ifdef MEASURE_CTRL_IRQ_EN
      irq_pend_q   <= 1'b0;
`endif
    end else begin
`ifdef MEASURE_CTRL_IRQ_EN
      if (clr_req_q) irq_pend_q <= 1'b0;
`endif
      if (abort_req_q && busy_q) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        ring_en_q   <= 1'b0;
        cnt_clear_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: if (start_req_q && !abort_req_q) begin
            state_q     <= CLEAR;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            cnt_clear_q <= 1'b1;
`ifdef MEASURE_CTRL_IRQ_EN
            irq_pend_q  <= 1'b0;
`endif
          end
          CLEAR: begin
            cnt_clear_q <= 1'b0;
            run_cnt_q   <= run_q;
            if (run_q == 32'h0) begin
              state_q      <= SETTLE;
              settle_cnt_q <= SET_W'(SETTLE_CYCLES);
            end else begin
              state_q   <= RUN;
              ring_en_q <= 1'b1;
            end
          end
          RUN: if (run_cnt_q == 32'd1) begin
            state_q      <= SETTLE;
            ring_en_q    <= 1'b0;
            settle_cnt_q <= SET_W'(SETTLE_CYCLES);
          end else begin
            run_cnt_q <= run_cnt_q - 32'd1;
          end
          SETTLE: if (settle_cnt_q == SET_W'(1)) state_q <= CAPTURE;
                  else settle_cnt_q <= settle_cnt_q - SET_W'(1);
          CAPTURE: begin
            ring_count_q <= ring_count;
            sum_q        <= adder_sum;
            state_q      <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
`ifdef MEASURE_CTRL_IRQ_EN
            irq_pend_q   <= 1'b1;
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign adder_a   = a_q[ADDER_W-1:0];
  assign adder_b   = b_q[ADDER_W-1:0];
  assign ring_en   = ring_en_q;
  assign cnt_clear = cnt_clear_q;
  assign busy      = busy_q;
  assign irq       = irq_bit;

endmodule

// File: doc/adder_measure_ctrl.md
Name: adder_measure_ctrl

Overview:
Wishbone-slave sequencer for the instrumented ripple adder.
- Holds operands A/B and drives them onto the adder.
- Clears the adder's ring-oscillator counter, then enables the ring for a programmed number of wb_clk_i cycles.
- After a settle window, captures the ring count and the adder sum into readable registers.
- Sits inside wrapped_project between the Wishbone bus and the adder/ring-oscillator datapath; optionally raises an interrupt on completion.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base address; decode compares wbs_adr_i[31:8] against BASE_ADDR[31:8].
ADDER_W, 32, operand and sum width.
COUNT_W, 32, ring counter width.
SETTLE_CYCLES, 4, cycles between ring disable and capture (≥1).

Ports:
wb_clk_i  in  1  system clock; the only clock.
wb_rst_n_i  in  1  asynchronous active-low reset; wrapper drives it with ~wb_rst_i.
wbs_stb_i  in  1  Wishbone strobe.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_we_i  in  1  write enable.
wbs_sel_i  in  4  byte selects.
wbs_adr_i  in  32  address.
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  acknowledge.
wbs_dat_o  out  32  read data.
adder_a  out  ADDER_W  operand A to adder.
adder_b  out  ADDER_W  operand B to adder.
adder_sum  in  ADDER_W  adder result.
ring_en  out  1  ring-oscillator enable.
cnt_clear  out  1  ring-counter synchronous clear.
ring_count  in  COUNT_W  ring-counter value; stable once ring_en is low.
busy  out  1  measurement in progress.
irq  out  1  completion interrupt; tied 0 when the optional feature is off.

Behaviour:
Reset (wb_rst_n_i low, asynchronous):
- All registers and outputs are 0.
- FSM is IDLE.

Register map (offset = wbs_adr_i[7:0]):
- 0x00 CTRL. Write: bit0 START, bit1 ABORT, bit2 IRQ_CLR. Read: bit0 busy, bit1 done, bit2 irq_pend.
- 0x04 A (RW).
- 0x08 B (RW).
- 0x0C RUN_CYCLES (RW, 32b).
- 0x10 RING_COUNT (RO).
- 0x14 SUM (RO).
- Any other offset: read 0, write ignored, still acked.

Bus handshake:
- Access = stb & cyc & address match.
- wbs_ack_o pulses high exactly 1 cycle, registered, the cycle after access is first seen.
- ack is low for at least 1 cycle between acks; no pipelining.
- wbs_dat_o is valid with ack and 0 otherwise.
- Writes honour wbs_sel_i per byte for A, B and RUN_CYCLES; CTRL acts on byte 0 only.
- Writes to A, B or RUN_CYCLES while busy are ignored, so operands stay stable during a run.

FSM: IDLE -> CLEAR -> RUN -> SETTLE -> CAPTURE -> DONE.
- IDLE/DONE + START -> CLEAR. done clears, busy goes to 1.
- CLEAR: cnt_clear=1 for exactly 1 cycle; load run counter = RUN_CYCLES. Next state is RUN, or SETTLE if RUN_CYCLES==0 (ring_en never asserted).
- RUN: ring_en=1 for exactly RUN_CYCLES cycles; the down-counter reaching 1 -> SETTLE.
- SETTLE: ring_en=0 for SETTLE_CYCLES cycles.
- CAPTURE: latch RING_COUNT <= ring_count and SUM <= adder_sum; 1 cycle.
- DONE: busy=0, done=1, irq_pend set. Stays in DONE until the next START.
- START-write ack -> cnt_clear latency is 1 cycle.
- Total busy cycles = 1 + RUN_CYCLES + SETTLE_CYCLES + 1.

Edge cases:
- START while busy: ignored.
- ABORT while busy: -> IDLE next cycle. ring_en drops that cycle; RING_COUNT/SUM unchanged; done stays 0; no irq.
- ABORT and START in the same write: ABORT wins, FSM ends in IDLE.
- IRQ_CLR and a new completion in the same cycle: the set wins.
- RUN_CYCLES = 0xFFFF_FFFF: runs the full count with no wrap.
- Reset mid-run: ring_en and cnt_clear drop immediately (asynchronous).

Optional Feature:
MEASURE_CTRL_IRQ_EN
- Defined: irq = irq_pend. irq_pend is set on entering DONE and cleared by an IRQ_CLR write or by START.
- Undefined: irq is tied 0 and CTRL bit2 reads 0.
- All other behaviour is identical either way.

Test Plan:
1. Write A=0x0000_0005, B=0x0000_0007, RUN_CYCLES=10, START -> cnt_clear high 1 cycle, ring_en high exactly 10 cycles, busy high 16 cycles (SETTLE_CYCLES=4), SUM reads 0x0000_000C, CTRL reads 0x2 (0x6 with irq enabled).
2. RUN_CYCLES=0, START -> ring_en never high, busy 6 cycles, RING_COUNT equals the value of ring_count at capture.
3. START with RUN_CYCLES=100; at RUN cycle 20 write ABORT -> ring_en low next cycle, FSM IDLE, RING_COUNT/SUM keep their previous values, irq stays 0.
4. While busy, write A=0xFFFF_FFFF and START -> adder_a unchanged, run length unchanged; each access acked exactly once, 1 cycle after stb.
5. With MEASURE_CTRL_IRQ_EN: complete a run -> irq=1; write IRQ_CLR -> irq=0 next cycle. Read offset 0x40 -> ack, data 0.
6. Assert wb_rst_n_i low mid-RUN -> ring_en, busy, wbs_ack_o go 0 without a clock edge; after release all registers read 0.
